// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded integer register file.
package regfile_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREG_DEFAULT  = 32;
    localparam int NREAD_DEFAULT = 2;
    localparam int ZERO_REG      = 0;

    // Address width for n registers; never below one bit so NREG=2 still works.
    function automatic int calc_aw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_bank.sv
// Raw register storage: async-cleared array, one write port, NREAD combinational reads.
module regfile_bank
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREG  = NREG_DEFAULT,
    parameter int NREAD = NREAD_DEFAULT,
    localparam int AW   = calc_aw(NREG)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic [NREAD*AW-1:0]   raddr,
    output logic [NREAD*XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem_reg [NREG];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
        assign rdata[gi*XLEN +: XLEN] = mem_reg[raddr[gi*AW +: AW]];
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with write-back bypass, hard-wired x0 and a per-register busy scoreboard
// used by the issue stage to stall on RAW/WAW hazards.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREG  = NREG_DEFAULT,
    parameter int NREAD = NREAD_DEFAULT,
    localparam int AW   = calc_aw(NREG)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREAD*AW-1:0]   rs_addr,
    output logic [NREAD*XLEN-1:0] rs_data,
    output logic [NREAD-1:0]      rs_busy,
    input  logic                  issue_valid,
    input  logic [AW-1:0]         issue_rd,
    output logic                  issue_ready,
    input  logic                  wb_valid,
    input  logic [AW-1:0]         wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  flush,
    output logic [NREG-1:0]       busy_vec
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    logic                  bank_we;
    logic [NREAD*XLEN-1:0] bank_rdata;
    logic [NREG-1:1]       busy_reg;
    logic [NREG-1:1]       busy_next;
    logic [NREG-1:0]       busy_full;
    logic                  wb_hit_issue;
    logic                  claim_accept;

    assign bank_we = wb_valid & (wb_rd != ZERO_ADDR);

    regfile_bank #(
        .XLEN  (XLEN),
        .NREG  (NREG),
        .NREAD (NREAD)
    ) u_bank (
        .CLK   (CLK),
        .RST   (RST),
        .we    (bank_we),
        .waddr (wb_rd),
        .wdata (wb_data),
        .raddr (rs_addr),
        .rdata (bank_rdata)
    );

    // x0 has no storage bit; it reads as never busy.
    assign busy_full = {busy_reg, 1'b0};
    assign busy_vec  = busy_full;

    for (genvar gi = 0; gi < NREAD; gi++) begin : g_port
        logic [AW-1:0] port_addr;
        logic          port_wb_hit;
        logic          port_is_zero;

        assign port_addr    = rs_addr[gi*AW +: AW];
        assign port_is_zero = (port_addr == ZERO_ADDR);
        assign port_wb_hit  = wb_valid & (wb_rd == port_addr);

        assign rs_data[gi*XLEN +: XLEN] = port_is_zero ? '0 :
                                          port_wb_hit  ? wb_data :
                                                         bank_rdata[gi*XLEN +: XLEN];
        assign rs_busy[gi] = busy_full[port_addr] & ~port_wb_hit & ~port_is_zero;
    end

    // A claim on a busy register is released in the very cycle its producer writes back.
    assign wb_hit_issue = wb_valid & (wb_rd == issue_rd);
    assign issue_ready  = ~issue_valid | (issue_rd == ZERO_ADDR) |
                          ~busy_full[issue_rd] | wb_hit_issue;
    assign claim_accept = issue_valid & issue_ready & ~flush;

    // New producer outranks the write-back of the previous one to the same register.
    for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
        assign busy_next[gi] = flush                                       ? 1'b0 :
                               (claim_accept && issue_rd == AW'(gi))       ? 1'b1 :
                               (wb_valid && wb_rd == AW'(gi))              ? 1'b0 :
                                                                             busy_reg[gi];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed vector table, async-reset sequence and randomized run against a behavioural model.
module tb_regfile_sb;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [9:0]  rs_addr = '0;
    logic [63:0] rs_data;
    logic [1:0]  rs_busy;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_ready;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        flush = 1'b0;
    logic [31:0] busy_vec;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_mem  [32];
    bit          m_busy [32];

    regfile_sb dut (
        .CLK(CLK), .RST(RST), .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .busy_vec(busy_vec)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  a0, a1;
        logic        iv;
        logic [4:0]  ird;
        logic        wbv;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        logic        fl;
        logic [31:0] e0, e1;
        logic        eb0, eb1, erdy;
        logic [31:0] ebv;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(logic [4:0] a0, logic [4:0] a1, logic iv, logic [4:0] ird,
                                logic wbv, logic [4:0] wbrd, logic [31:0] wbd, logic fl,
                                logic [31:0] e0, logic [31:0] e1, logic eb0, logic eb1,
                                logic erdy, logic [31:0] ebv);
        vec_t v;
        v.a0 = a0; v.a1 = a1; v.iv = iv; v.ird = ird; v.wbv = wbv; v.wbrd = wbrd;
        v.wbd = wbd; v.fl = fl; v.e0 = e0; v.e1 = e1; v.eb0 = eb0; v.eb1 = eb1;
        v.erdy = erdy; v.ebv = ebv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [4:0] a0, input logic [4:0] a1, input logic iv,
                         input logic [4:0] ird, input logic wbv, input logic [4:0] wbrd,
                         input logic [31:0] wbd, input logic fl);
        rs_addr = {a1, a0};
        issue_valid = iv; issue_rd = ird;
        wb_valid = wbv; wb_rd = wbrd; wb_data = wbd; flush = fl;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wb_valid && wb_rd == a) return wb_data;
        return m_mem[a];
    endfunction

    function automatic logic m_rbusy(input logic [4:0] a);
        return (a != 0) && m_busy[a] && !(wb_valid && wb_rd == a);
    endfunction

    function automatic logic m_ready();
        return !issue_valid || issue_rd == 0 || !m_busy[issue_rd] || (wb_valid && wb_rd == issue_rd);
    endfunction

    function automatic logic [31:0] m_bvec();
        logic [31:0] v = '0;
        for (int r = 1; r < 32; r++) v[r] = m_busy[r];
        return v;
    endfunction

    task automatic m_reset();
        for (int r = 0; r < 32; r++) begin
            m_mem[r] = '0;
            m_busy[r] = 0;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_d0"}, rs_data[31:0], m_read(rs_addr[4:0]));
        chk({tag, "_d1"}, rs_data[63:32], m_read(rs_addr[9:5]));
        chk({tag, "_b0"}, {31'b0, rs_busy[0]}, {31'b0, m_rbusy(rs_addr[4:0])});
        chk({tag, "_b1"}, {31'b0, rs_busy[1]}, {31'b0, m_rbusy(rs_addr[9:5])});
        chk({tag, "_rdy"}, {31'b0, issue_ready}, {31'b0, m_ready()});
        chk({tag, "_bvec"}, busy_vec, m_bvec());
    endtask

    // Advance model through the coming clock edge using the inputs currently driven.
    task automatic clock_edge();
        bit acc;
        acc = issue_valid && m_ready() && !flush;
        @(posedge CLK);
        if (wb_valid && wb_rd != 0) m_mem[wb_rd] = wb_data;
        if (flush) begin
            for (int r = 0; r < 32; r++) m_busy[r] = 0;
        end else begin
            if (wb_valid) m_busy[wb_rd] = 0;
            if (acc && issue_rd != 0) m_busy[issue_rd] = 1;
        end
        #1;
    endtask

    initial begin
        tbl[0]  = mk(0, 0, 1, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[2]  = mk(5, 0, 0, 0, 1, 5, 32'h12345678, 0, 32'h12345678, 0, 0, 0, 1, 0);
        tbl[3]  = mk(5, 5, 0, 0, 0, 0, 0, 0, 32'h12345678, 32'h12345678, 0, 0, 1, 0);
        tbl[4]  = mk(7, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[5]  = mk(7, 0, 1, 7, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h80);
        tbl[6]  = mk(7, 0, 1, 7, 1, 7, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 0, 0, 0, 1, 32'h80);
        tbl[7]  = mk(7, 0, 0, 0, 0, 0, 0, 0, 32'hA5A5A5A5, 0, 1, 0, 1, 32'h80);
        tbl[8]  = mk(0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80);
        tbl[9]  = mk(0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h88);
        tbl[10] = mk(9, 3, 1, 9, 0, 0, 0, 1, 0, 0, 0, 1, 1, 32'h98);
        tbl[11] = mk(9, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[12] = mk(0, 3, 0, 0, 1, 3, 32'hCAFEF00D, 0, 0, 32'hCAFEF00D, 0, 0, 1, 0);
        tbl[13] = mk(3, 0, 0, 0, 0, 0, 0, 0, 32'hCAFEF00D, 0, 0, 0, 1, 0);

        m_reset();
        @(posedge CLK); #1;
        #1 chk("reset_bvec", busy_vec, 32'h0);
        chk("reset_rdy", {31'b0, issue_ready}, 32'h1);
        @(posedge CLK); #1;
        RST = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(5'(2*i), 5'(2*i+1), 0, 0, 0, 0, 0, 0);
            #1 check_model("rst_read");
            clock_edge();
        end

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].a0, tbl[i].a1, tbl[i].iv, tbl[i].ird, tbl[i].wbv, tbl[i].wbrd,
                  tbl[i].wbd, tbl[i].fl);
            #1;
            chk($sformatf("vec%0d_d0", i), rs_data[31:0], tbl[i].e0);
            chk($sformatf("vec%0d_d1", i), rs_data[63:32], tbl[i].e1);
            chk($sformatf("vec%0d_busy", i), {30'b0, rs_busy}, {30'b0, tbl[i].eb1, tbl[i].eb0});
            chk($sformatf("vec%0d_rdy", i), {31'b0, issue_ready}, {31'b0, tbl[i].erdy});
            chk($sformatf("vec%0d_bvec", i), busy_vec, tbl[i].ebv);
            $display("[TB] vec %0d a0=%0d a1=%0d d0=%h d1=%h busy=%b rdy=%b bvec=%h",
                     i, tbl[i].a0, tbl[i].a1, rs_data[31:0], rs_data[63:32], rs_busy,
                     issue_ready, busy_vec);
            clock_edge();
        end

        // Asynchronous reset between edges.
        drive(10, 12, 0, 0, 1, 10, 32'h11111111, 0);
        clock_edge();
        drive(10, 12, 1, 12, 0, 0, 0, 0);
        clock_edge();
        drive(10, 12, 1, 12, 0, 0, 0, 0);
        #1 check_model("pre_arst");
        #1 RST = 1'b1;
        #1;
        chk("arst_d0", rs_data[31:0], 32'h0);
        chk("arst_d1", rs_data[63:32], 32'h0);
        chk("arst_busy", {30'b0, rs_busy}, 32'h0);
        chk("arst_bvec", busy_vec, 32'h0);
        chk("arst_rdy", {31'b0, issue_ready}, 32'h1);
        $display("[TB] async reset at %0t d0=%h bvec=%h", $time, rs_data[31:0], busy_vec);
        m_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge CLK); #1;
        RST = 1'b0;

        for (int i = 0; i < 400; i++) begin
            drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 19) == 0));
            #1 check_model($sformatf("rnd%0d", i));
            clock_edge();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
